mmio_router: RTL
================

Name: mmio_router

Overview:
Parametrised MMIO front end that replaces the fixed two-device MMIO responder.
- Accepts one request at a time from the memory stage over the existing start/req/ack handshake.
- Decodes the address against NDEV base/mask windows and forwards the access to one device port over a valid/ready handshake.
- Adds byte-strobe writes, a per-access timeout, and an error response for unmapped or illegal accesses.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width; must be a multiple of 8.
- NDEV, 4, number of device ports (1..16).
- DEV_BASE, all zeros, packed NDEV*ADDR_W vector; slot k occupies bits [k*ADDR_W +: ADDR_W].
- DEV_MASK, all ones, packed NDEV*ADDR_W vector of compare masks; slot k hits when (addr & mask_k) == (base_k & mask_k).
- TIMEOUT, 255, maximum number of cycles spent in ISSUE before the access is aborted; must be >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse from the memory stage; sampled only in IDLE.
- ack  in  1  requester has consumed the response.
- req  out  1  response valid; held until ack.
- ren  in  1  read access.
- wen  in  1  write access.
- addr  in  ADDR_W  access address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  write byte enables.
- rdata  out  DATA_W  read data; 0 for writes and errors.
- err  out  1  response is an error; valid while req=1.
- dev_valid  out  NDEV  one-hot; access presented to slot k.
- dev_we  out  1  1 = write, 0 = read.
- dev_addr  out  ADDR_W  registered request address.
- dev_wdata  out  DATA_W  registered write data.
- dev_wstrb  out  DATA_W/8  registered byte enables.
- dev_ready  in  NDEV  slot k accepts the access and completes it this cycle.
- dev_rdata  in  NDEV*DATA_W  slot k read data, valid in the cycle dev_ready[k]=1.

Behaviour:
- Reset: asynchronous on rst_n low. State = IDLE. Outputs req, err, rdata, dev_valid, dev_we, dev_addr, dev_wdata, dev_wstrb and the timeout counter all go to 0. Reset in ISSUE or RESP drops dev_valid and req immediately; the access is abandoned and no response is produced.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, start=0: remain in IDLE.
- IDLE, start=1: latch addr, wdata, wstrb and direction (dev_we=wen), then classify. Decode is priority: the lowest matching slot index wins.
  - ren=1 and wen=1: go to RESP with err=1; no device access.
  - ren=0 and wen=0: go to RESP with err=0, rdata=0.
  - wen=1 with wstrb all zero: go to RESP with err=0; no device access.
  - No slot match: go to RESP with err=1, rdata=0.
  - Hit on slot k: go to ISSUE with dev_valid[k]=1 and the counter cleared.
- ISSUE: dev_valid, dev_we, dev_addr, dev_wdata and dev_wstrb are held stable.
  - dev_ready[k]=1: capture dev_rdata slot k into rdata (reads only; writes leave rdata=0), set err=0, drop dev_valid, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without ready, drop dev_valid and go to RESP with err=1, rdata=0.
  - dev_ready bits of non-selected slots are ignored.
- RESP: req=1; rdata and err are held stable.
  - ack=1: go to IDLE; req, err and rdata clear to 0 in the same edge.
  - A start arriving while req=1 is ignored.
- ack outside RESP is ignored.
- Latency:
  - Error or no-access response: start sampled at edge T, req=1 after edge T+1.
  - Device hit with dev_ready in the first valid cycle: dev_valid=1 after T+1, req=1 after T+2.
- Only one access is outstanding at any time.
- Width rules: dev_wstrb is passed through unmodified; rdata is never sign-extended or shifted. Byte-lane extraction belongs to the requester.

Decomposition:
- Shared package mmio_pkg:
  - FSM state encoding.
  - Default DEV_RTC and DEV_MTIMECMP base/mask constants.
  - Helper function for slot index width ($clog2(NDEV), minimum 1).
- Sub-module mmio_addr_decode (combinational):
  - Inputs: addr, DEV_BASE, DEV_MASK.
  - Outputs: hit, one-hot sel, encoded idx.
  - Reused by the future multi-hart CLINT wrapper.

Test Plan:
- Bench configuration for all scenarios: NDEV=2; slot0 base 0x0200_4000, mask ~0x7; slot1 base 0x0200_BFF8, mask ~0x7; TIMEOUT=8.
- Read hit with immediate ready: start, ren=1, addr=0x0200_BFF8; dev_ready[1] in the first valid cycle with data 0x1234_5678_9ABC_DEF0 -> dev_valid=2'b10 for 1 cycle; req=1 two cycles after start, rdata=0x1234_5678_9ABC_DEF0, err=0; on ack, rdata=0 and req=0.
- Strobed write: wen=1, addr=0x0200_4000, wdata=0xAA, wstrb=0x0F; dev_ready[0] delayed 3 cycles -> dev_valid=2'b01 held 4 cycles, dev_wstrb=0x0F, dev_wdata=0xAA; then req=1, rdata=0, err=0.
- Unmapped read: addr=0x1000_0000, ren=1 -> no dev_valid pulse; req=1 one cycle after start, err=1, rdata=0.
- Timeout: read of slot0 with dev_ready held at 0 -> dev_valid high exactly 8 cycles then low; req=1 with err=1; a later read of slot1 completes normally.
- Illegal and edge handshakes:
  - ren=wen=1 -> err=1 with no device access.
  - wen=1, wstrb=0 -> err=0 with no device access.
  - start pulsed while req=1 -> ignored; exactly one response.
- Reset mid-ISSUE: drive rst_n low between clock edges while dev_valid=1 -> dev_valid and req drop before the next edge; after release, state is IDLE and a fresh read completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO router and its address decoder: FSM encoding,
// default device windows and a slot-index width helper.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [63:0] DEV_RTC_BASE      = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] DEV_RTC_MASK      = ~64'h7;
  localparam logic [63:0] DEV_MTIMECMP_BASE = 64'h0000_0000_0200_4000;
  localparam logic [63:0] DEV_MTIMECMP_MASK = ~64'h7;

  // Bits needed to hold values 0..n-1, never less than 1.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational base/mask window decoder; the lowest matching slot index wins.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int NDEV   = 4,
  parameter int IDX_W  = idx_width(NDEV)
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic [NDEV*ADDR_W-1:0] dev_base,
  input  logic [NDEV*ADDR_W-1:0] dev_mask,
  output logic                   hit,
  output logic [NDEV-1:0]        sel,
  output logic [IDX_W-1:0]       idx
);

  // Scan from the top down so a lower matching slot overrides a higher one.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = NDEV - 1; k >= 0; k--) begin
      if ((addr & dev_mask[k*ADDR_W +: ADDR_W]) ==
          (dev_base[k*ADDR_W +: ADDR_W] & dev_mask[k*ADDR_W +: ADDR_W])) begin
        hit    = 1'b1;
        sel    = '0;
        sel[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mmio_router.sv
// MMIO front end: takes one start/req/ack request, decodes it to a device slot,
// runs a valid/ready access with timeout and returns data or an error.
module mmio_router
  import mmio_pkg::*;
#(
  parameter int                     ADDR_W   = 64,
  parameter int                     DATA_W   = 64,
  parameter int                     NDEV     = 4,
  parameter logic [NDEV*ADDR_W-1:0] DEV_BASE = '0,
  parameter logic [NDEV*ADDR_W-1:0] DEV_MASK = '1,
  parameter int                     TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   ack,
  output logic                   req,
  input  logic                   ren,
  input  logic                   wen,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W/8-1:0]    wstrb,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic [NDEV-1:0]        dev_valid,
  output logic                   dev_we,
  output logic [ADDR_W-1:0]      dev_addr,
  output logic [DATA_W-1:0]      dev_wdata,
  output logic [DATA_W/8-1:0]    dev_wstrb,
  input  logic [NDEV-1:0]        dev_ready,
  input  logic [NDEV*DATA_W-1:0] dev_rdata,
  output logic [1:0]             dbg_state
);

  localparam int IDX_W = idx_width(NDEV);
  localparam int CNT_W = idx_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  // Device handshake: an access to slot k is transferred in the cycle where
  // dev_valid[k] and dev_ready[k] are both 1; until then every dev_* output
  // stays stable. Requester side: req stays high until the cycle ack is seen.

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NDEV-1:0]     valid_q, valid_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                dec_hit;
  logic [NDEV-1:0]     dec_sel;
  logic [IDX_W-1:0]    dec_idx;
  logic [DATA_W-1:0]   slot_rdata;

  mmio_addr_decode #(
    .ADDR_W (ADDR_W),
    .NDEV   (NDEV),
    .IDX_W  (IDX_W)
  ) u_decode (
    .addr     (addr),
    .dev_base (DEV_BASE),
    .dev_mask (DEV_MASK),
    .hit      (dec_hit),
    .sel      (dec_sel),
    .idx      (dec_idx)
  );

  always_comb begin
    slot_rdata = '0;
    for (int k = 0; k < NDEV; k++) begin
      if (idx_q == IDX_W'(k)) slot_rdata = dev_rdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = addr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          we_d    = wen;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_RESP;
          if (ren && wen) begin
            err_d = 1'b1;
          end else if (!ren && !wen) begin
            err_d = 1'b0;
          end else if (wen && (wstrb == '0)) begin
            err_d = 1'b0;
          end else if (!dec_hit) begin
            err_d = 1'b1;
          end else begin
            valid_d = dec_sel;
            idx_d   = dec_idx;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // Only the ready bit of the slot being driven is looked at.
        if ((dev_ready & valid_q) != '0) begin
          rdata_d = we_q ? '0 : slot_rdata;
          err_d   = 1'b0;
          valid_d = '0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          rdata_d = '0;
          err_d   = 1'b1;
          valid_d = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (ack) begin
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      valid_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      idx_q   <= idx_d;
    end
  end

  assign req       = (state_q == ST_RESP);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign dev_valid = valid_q;
  assign dev_we    = we_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign dev_wstrb = wstrb_q;
  assign dbg_state = state_q;

endmodule
